fwd_operand_stage: RTL

- Parametrised successor to the fixed 3-input forwarding mux.
- Resolves the rs1 and rs2 operands for the instruction leaving ID, choosing between register-file data and NUM_FWD producer stages by priority compare.
- Detects load-use hazards and stalls ID when a needed producer's data is not yet available.
- Registers resolved operands into the ID/EX boundary with a valid/ready handshake, flush and a stall-cycle performance counter.

---
 rtl/fwd_pkg.sv | 19 +
 rtl/fwd_src_select.sv | 57 +++++
 rtl/fwd_operand_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the operand forwarding stage.
// Covers select-code sizing and the indexing of flattened per-producer buses.
package fwd_pkg;

  localparam int unsigned SEL_RF = 0;

  function automatic int unsigned sel_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

  function automatic int unsigned slice_hi(input int unsigned k, input int unsigned w);
    return k * w + w - 1;
  endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Single-operand source resolution: priority compare against the producers, then a data mux.
// need_ok flags that the chosen producer's result is not yet available.
module fwd_src_select
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned SELW    = sel_width(NUM_FWD)
) (
  input  logic [REG_AW-1:0]         rs,
  input  logic [XLEN-1:0]           rf_data,
  input  logic [NUM_FWD-1:0]        fwd_wr_en,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_data_ok,
  output logic [SELW-1:0]           sel,
  output logic [XLEN-1:0]           data,
  output logic                      need_ok
);

  logic [NUM_FWD-1:0] match;

  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      match[k] = (rs != '0) && fwd_wr_en[k] &&
                 (fwd_rd[slice_lo(k, REG_AW) +: REG_AW] == rs);
    end
  end

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    sel = SELW'(SEL_RF);
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (match[NUM_FWD-1-i]) begin
        sel = SELW'(NUM_FWD - i);
      end
    end
  end

  // Codes with no matching arm leave data at zero.
  always_comb begin
    data    = '0;
    need_ok = 1'b0;
    if (sel == SELW'(SEL_RF)) begin
      data = rf_data;
    end
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (sel == SELW'(k + 1)) begin
        data    = fwd_data[slice_lo(k, XLEN) +: XLEN];
        need_ok = !fwd_data_ok[k];
      end
    end
  end

endmodule

// File: rtl/fwd_operand_stage.sv
// Resolves rs1/rs2 operands from the register file or NUM_FWD producers, stalls on load-use,
// and registers the result into the ID/EX boundary with valid/ready, flush and a stall counter.
module fwd_operand_stage
  import fwd_pkg::*;
#(
  parameter  int unsigned XLEN    = 64,
  parameter  int unsigned REG_AW  = 5,
  parameter  int unsigned NUM_FWD = 2,
  parameter  int unsigned CNT_W   = 32,
  localparam int unsigned SELW    = sel_width(NUM_FWD)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [REG_AW-1:0]         id_rs1,
  input  logic [REG_AW-1:0]         id_rs2,
  input  logic [XLEN-1:0]           id_rs1_data,
  input  logic [XLEN-1:0]           id_rs2_data,
  input  logic [NUM_FWD-1:0]        fwd_wr_en,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_data_ok,
  input  logic                      flush,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [XLEN-1:0]           ex_op1,
  output logic [XLEN-1:0]           ex_op2,
  output logic [SELW-1:0]           ex_sel1,
  output logic [SELW-1:0]           ex_sel2,
  output logic                      hazard_stall,
  output logic [CNT_W-1:0]          stall_cycles
);

  logic [SELW-1:0] sel1, sel2;
  logic [XLEN-1:0] data1, data2;
  logic            wait1, wait2;
  logic            xfer;

  fwd_src_select #(
    .XLEN    (XLEN),
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD),
    .SELW    (SELW)
  ) u_sel_rs1 (
    .rs          (id_rs1),
    .rf_data     (id_rs1_data),
    .fwd_wr_en   (fwd_wr_en),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .fwd_data_ok (fwd_data_ok),
    .sel         (sel1),
    .data        (data1),
    .need_ok     (wait1)
  );

  fwd_src_select #(
    .XLEN    (XLEN),
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD),
    .SELW    (SELW)
  ) u_sel_rs2 (
    .rs          (id_rs2),
    .rf_data     (id_rs2_data),
    .fwd_wr_en   (fwd_wr_en),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .fwd_data_ok (fwd_data_ok),
    .sel         (sel2),
    .data        (data2),
    .need_ok     (wait2)
  );

  assign hazard_stall = id_valid && (wait1 || wait2);
  assign id_ready     = !flush && !hazard_stall && (!ex_valid || ex_ready);
  assign xfer         = id_valid && id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (xfer) begin
      ex_valid <= 1'b1;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // id_ready already excludes flush, so a flush cycle never captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_op1  <= '0;
      ex_op2  <= '0;
      ex_sel1 <= '0;
      ex_sel2 <= '0;
    end else if (xfer) begin
      ex_op1  <= data1;
      ex_op2  <= data2;
      ex_sel1 <= sel1;
      ex_sel2 <= sel2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (hazard_stall && !flush && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
